// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter states and the BTB entry layout.
// Entry fields are sized for the widest supported XLEN; narrower tags are zero-extended.
package bp_pkg;

  localparam int BP_XLEN  = 32;
  localparam int BP_TAG_W = BP_XLEN - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    ctr_t                ctr;
  } btb_entry_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

endpackage

// File: rtl/sat_counter2.sv
// One step of a 2-bit saturating counter toward the resolved branch direction.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr_in,
  input  logic taken,
  output ctr_t ctr_out
);

  always_comb begin
    // NOTE: assign a default before any branching so no path leaves ctr_out unassigned (no latch).
    ctr_out = ctr_in;
    unique case (ctr_in)
      SNT: ctr_out = taken ? WNT : SNT;
      WNT: ctr_out = taken ? WT  : SNT;
      WT:  ctr_out = taken ? ST  : WNT;
      ST:  ctr_out = taken ? ST  : WT;
      default: ctr_out = ctr_in;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: 0-cycle fetch lookup, EX-stage update,
// mispredict/recovery generation and branch/mispredict performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_next_pc_f,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_next_pc,
  output logic            mispredict,
  output logic [XLEN-1:0] recover_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_BITS-1:0] idx_f, idx_u;
  logic [BP_TAG_W-1:0] tag_f, tag_u;
  btb_entry_t          ent_f, ent_u, upd_entry_d;
  logic                hit_f, hit_u, upd_we;
  ctr_t                ctr_step;
  logic [31:0]         branch_count_q, branch_count_d;
  logic [31:0]         mispredict_count_q, mispredict_count_d;

  // Fetch-side lookup reads the pre-update array, so a same-cycle update is not bypassed.
  assign idx_f = pc_f[IDX_BITS+1:2];
  assign tag_f = BP_TAG_W'(pc_f[XLEN-1:IDX_BITS+2]);
  assign ent_f = btb_q[idx_f];
  assign hit_f = ent_f.valid && (ent_f.tag == tag_f);

  assign pred_taken_f   = hit_f && (ent_f.ctr inside {WT, ST});
  assign pred_next_pc_f = pred_taken_f ? XLEN'(ent_f.target) : pc_f + XLEN'(4);

  assign mispredict = upd_valid &&
                      (upd_taken ? (upd_pred_next_pc != upd_target) : upd_pred_taken);
  assign recover_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  assign idx_u = upd_pc[IDX_BITS+1:2];
  assign tag_u = BP_TAG_W'(upd_pc[XLEN-1:IDX_BITS+2]);
  assign ent_u = btb_q[idx_u];
  assign hit_u = ent_u.valid && (ent_u.tag == tag_u);

  sat_counter2 u_sat (
    .ctr_in  (ent_u.ctr),
    .taken   (upd_taken),
    .ctr_out (ctr_step)
  );

  always_comb begin
    upd_we      = 1'b0;
    upd_entry_d = ent_u;
    if (upd_valid) begin
      if (hit_u) begin
        upd_we          = 1'b1;
        upd_entry_d.ctr = ctr_step;
        if (upd_taken) upd_entry_d.target = BP_XLEN'(upd_target);
      end else if (upd_taken) begin
        // A taken miss claims the slot, evicting whatever alias lived there.
        upd_we      = 1'b1;
        upd_entry_d = '{valid: 1'b1, tag: tag_u, target: BP_XLEN'(upd_target), ctr: CTR_ALLOC};
      end
    end
  end

  assign branch_count_d     = branch_count_q + 32'(upd_valid);
  assign mispredict_count_d = mispredict_count_q + 32'(mispredict);

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the BTB is a flop array, not a RAM, so every entry can and must be cleared here.
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      if (upd_we) btb_q[idx_u] <= upd_entry_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor feeding the fetch-stage PC select logic.
- Uses a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Each fetch cycle it predicts taken/not-taken and the next fetch PC from the current PC.
- Each resolved branch from EX updates the table, flags a mispredict and supplies the recovery PC.
- Also keeps branch and mispredict performance counters.

Parameters:
IDX_BITS, 4, BTB index width; 2^IDX_BITS entries.
XLEN, 32, address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-low; state clears on a clk edge with rst=0.
pc_f  in  XLEN  current fetch PC.
pred_taken_f  out  1  predicted taken for pc_f.
pred_next_pc_f  out  XLEN  predicted next fetch PC.
upd_valid  in  1  a resolved branch/jump is in EX this cycle; EX deasserts on bubbles and flushes.
upd_pc  in  XLEN  PC of the resolved instruction.
upd_taken  in  1  actual outcome.
upd_target  in  XLEN  actual target.
upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
upd_pred_next_pc  in  XLEN  predicted next PC carried down the pipe.
mispredict  out  1  redirect request to the PC mux.
recover_pc  out  XLEN  correct next PC when mispredict=1.
branch_count  out  32  resolved branches since reset.
mispredict_count  out  32  mispredicts since reset.

Behaviour:
- Indexing:
  - idx = pc[IDX_BITS+1:2]; tag = pc[XLEN-1:IDX_BITS+2].
  - Entry = {valid, tag, target, ctr[1:0]}.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11; predict taken iff ctr[1]=1.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[idx] & tag match.
  - pred_taken_f = hit & ctr[1].
  - pred_next_pc_f = pred_taken_f ? target : pc_f+4 (mod 2^XLEN).
- Update (registered, visible on the cycle after the edge) when upd_valid=1:
  - hit, taken: ctr saturating +1 (ST stays ST); target <= upd_target.
  - hit, not taken: ctr saturating -1 (SNT stays SNT); target unchanged.
  - miss, taken: allocate/overwrite entry: valid=1, tag, target=upd_target, ctr=WT.
  - miss, not taken: no change; no allocation.
- Mispredict (combinational from update inputs):
  - mispredict = upd_valid & (upd_taken ? (upd_pred_next_pc != upd_target) : upd_pred_taken).
  - recover_pc = upd_taken ? upd_target : upd_pc+4.
  - recover_pc is don't-care when mispredict=0.
- Perf counters:
  - branch_count +1 per upd_valid cycle.
  - mispredict_count +1 per mispredict cycle.
  - Both wrap 0xFFFFFFFF -> 0 silently.
- Simultaneous lookup and update at the same idx: lookup returns pre-update contents (no bypass); the new state is visible next cycle.
- Aliasing: a different tag at the same idx is a miss. A taken update evicts the old entry.
- Reset (any cycle, including mid-update):
  - On the edge with rst=0: all valid=0, all ctr=WNT, targets=0, counters=0. A coincident update is discarded.
  - Post-reset outputs: pred_taken_f=0, pred_next_pc_f=pc_f+4.
  - mispredict and recover_pc follow the inputs combinationally; the PC stage ignores them during reset.
- Stall: no stall input. Fetch stall only holds pc_f. EX guarantees at most one upd_valid per instruction.

Decomposition:
- Package bp_pkg holds:
  - ctr_t 2-bit enum SNT/WNT/WT/ST;
  - btb_entry_t struct {valid, tag, target, ctr};
  - constant CTR_RESET=WNT;
  - constant CTR_ALLOC=WT.
- One sub-module: sat_counter2. Inputs ctr_in and taken; output ctr_out; combinational saturating step, instantiated in the update path.

Test Plan:
- Reset, then pc_f=0x100 -> pred_taken_f=0, pred_next_pc_f=0x104; both perf counters = 0.
- Update: upd_pc=0x100, taken, target 0x80, pred_taken=0, pred_next_pc=0x104 -> same cycle mispredict=1, recover_pc=0x80. Next cycle pc_f=0x100 -> pred_taken_f=1, pred_next_pc_f=0x80. branch_count=1, mispredict_count=1.
- From WT at 0x100: two not-taken updates -> ctr WNT then SNT; lookup gives pred_next_pc_f=0x104. One taken update -> WNT, still not taken. Counter saturation checked at both ST and SNT with repeated updates.
- Alias (IDX_BITS=4): with 0x100 valid, pc_f=0x140 -> miss, pred_next_pc_f=0x144. Taken update at 0x140, target 0x200 -> 0x100 now misses.
- Same cycle: pc_f=0x100 and upd_pc=0x100 taken -> lookup shows old prediction that cycle, new prediction next cycle.
- Mid-operation reset: rst=0 for one edge coincident with upd_valid=1 -> all entries miss afterwards, counters=0, the discarded update is not counted.
